// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle RV32I control FSM with memory handshakes, illegal/timeout trap and retire counter
module multicycle_controller #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [2:0]  state,
  output logic        trap,
  output logic [31:0] instret
);
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;
  state_t st;
  logic [3:0] timeout;
  logic [6:0] opcode, f7;
  logic [2:0] f3, alu_fn;
  logic is_r, is_i, is_lw, is_sw, is_beq, is_jal, legal, retire, wait_out;
  logic in_fetch, in_ex, in_mem, in_wb, unused;
  assign opcode = instruction[6:0];
  assign f3 = instruction[14:12];
  assign f7 = instruction[31:25];
  assign unused = ^instruction[24:15];
  assign is_r = opcode == 7'b0110011 && f3 != 3'b011 && (f7 == 7'b0 || (f7 == 7'b0100000 && f3 == 3'b000));
  assign is_i = opcode == 7'b0010011 && f3 != 3'b011 && (f7 == 7'b0 || (f3 != 3'b001 && f3 != 3'b101));
  assign is_lw = opcode == 7'b0000011 && f3 == 3'b010;
  assign is_sw = opcode == 7'b0100011 && f3 == 3'b010;
  assign is_beq = opcode == 7'b1100011 && f3 == 3'b000;
  assign is_jal = opcode == 7'b1101111;
  assign legal = is_r || is_i || is_lw || is_sw || is_beq || is_jal;
  assign alu_fn = f3 == 3'b000 ? {2'b00, is_r && f7[5]} :
                  f3 == 3'b111 ? 3'd2 :
                  f3 == 3'b110 ? 3'd3 :
                  f3 == 3'b100 ? 3'd4 :
                  f3 == 3'b001 ? 3'd5 :
                  f3 == 3'b101 ? 3'd6 : 3'd7;
  assign in_fetch = !reset && st == FETCH;
  assign in_ex = !reset && st == EXECUTE;
  assign in_mem = !reset && st == MEM;
  assign in_wb = !reset && st == WRITEBACK;
  assign imem_req = in_fetch;
  assign ir_write = in_fetch && imem_ready;
  assign pc_write = (in_fetch && imem_ready) || (in_ex && (is_jal || (is_beq && alu_zero)));
  assign pc_src = in_ex && is_beq ? 2'd1 : in_ex && is_jal ? 2'd2 : 2'd0;
  assign dmem_req = in_mem;
  assign dmem_we = in_mem && is_sw;
  assign alu_op = in_ex ? (is_beq ? 3'd1 : (is_r || is_i) ? alu_fn : 3'd0) : 3'd0;
  assign alu_src_imm = (in_ex || in_mem) && (is_i || is_lw || is_sw);
  assign reg_write = in_wb && instruction[11:7] != 5'd0;
  assign wb_sel = in_wb ? (is_lw ? 2'd1 : is_jal ? 2'd2 : 2'd0) : 2'd0;
  assign state = st;
  assign trap = st == TRAP;
  assign wait_out = timeout == 4'(MEM_WAIT_MAX);
  assign retire = (st == EXECUTE && is_beq) || (st == MEM && dmem_ready && is_sw) || st == WRITEBACK;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= FETCH;
      timeout <= 4'd0;
      instret <= 32'd0;
    end else begin
      timeout <= 4'd0;
      case (st)
        FETCH: begin
          st <= imem_ready ? DECODE : wait_out ? TRAP : FETCH;
          timeout <= imem_ready ? 4'd0 : timeout + 4'd1;
        end
        DECODE: st <= legal ? EXECUTE : TRAP;
        EXECUTE: st <= (is_lw || is_sw) ? MEM : is_beq ? FETCH : WRITEBACK;
        MEM: begin
          st <= dmem_ready ? (is_lw ? WRITEBACK : FETCH) : wait_out ? TRAP : MEM;
          timeout <= dmem_ready ? 4'd0 : timeout + 4'd1;
        end
        WRITEBACK: st <= FETCH;
        default: st <= TRAP;
      endcase
      if (retire) instret <= instret + 32'd1;
    end
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM that sequences the RV32I datapath (PC register, instruction memory, register file, ALU, sign extender) over several cycles per instruction instead of one. It replaces the combinational control unit. It handshakes with the instruction and data memories, emits per-state datapath strobes and the ALU operation, traps on unsupported encodings, and counts retired instructions.

Parameters:
MEM_WAIT_MAX, 15, cycles a memory request may wait for ready before a trap (timeout counter width 4 bits)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
instruction  in  32  instruction register contents (valid from DECODE onward)
alu_zero  in  1  ALU result == 0 (BEQ compare)
imem_ready  in  1  instruction memory data valid this cycle
dmem_ready  in  1  data memory access complete this cycle
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
ir_write  out  1  latch instruction register and old_pc
pc_write  out  1  update PC
pc_src  out  2  0=pc+4, 1=old_pc+imm_b, 2=old_pc+imm_j
reg_write  out  1  register file write enable
wb_sel  out  2  0=ALU result, 1=load data, 2=old_pc+4
alu_op  out  3  ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SLT=7
alu_src_imm  out  1  ALU operand b = sign-extended imm_i/imm_s
state  out  3  current FSM state (debug)
trap  out  1  sticky illegal-instruction / timeout flag
instret  out  32  retired instruction count

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5. Registered state; strobes are combinational from state, instruction and ready inputs.
- Reset: state=FETCH, trap=0, instret=0, timeout=0. While reset=1, all strobes are forced to 0. Reset in any state, including MEM with dmem_req high, returns to FETCH the next cycle. No memory transaction completes.
- FETCH: imem_req=1. On imem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE. Otherwise stay and increment timeout.
- DECODE: one cycle with no strobes. Classify the instruction. Illegal goes to TRAP, otherwise EXECUTE.
- Supported encodings:
  - R-type (0110011): funct3 000+f7 0000000 ADD, 000+0100000 SUB, 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL, 010 SLT. Every non-SUB case requires f7=0.
  - I-ALU (0010011): same funct3 map with alu_src_imm=1. 000 is always ADD. 001/101 require f7=0.
  - LW (0000011, f3 010) and SW (0100011, f3 010): ADD with alu_src_imm=1.
  - BEQ (1100011, f3 000): SUB.
  - JAL (1101111).
  - Anything else is illegal.
- EXECUTE: alu_op/alu_src_imm driven per decode.
  - R/I go to WRITEBACK.
  - LW/SW go to MEM.
  - BEQ: pc_write=alu_zero, pc_src=1, then FETCH (retire).
  - JAL: pc_write=1, pc_src=2, then WRITEBACK.
- MEM: dmem_req=1, dmem_we=1 for SW, alu_op and alu_src_imm held.
  - On dmem_ready: LW goes to WRITEBACK, SW goes to FETCH (retire).
  - Otherwise increment timeout.
- WRITEBACK: reg_write=1 unless rd (instruction[11:7]) == 0. wb_sel is 0 for R/I, 1 for LW, 2 for JAL. Then FETCH (retire).
- Latency with ready high on the first request cycle: BEQ 3, R/I/SW/JAL 4, LW 5 cycles.
- Timeout: counter clears on every ready-accepted cycle and on state entry. A wait exceeding MEM_WAIT_MAX cycles goes to TRAP.
- TRAP: trap=1, all strobes 0. Exit only by reset.
- instret increments by 1 on each retiring transition, wrapping 0xFFFFFFFF->0. It does not increment on TRAP.
- A ready input asserted outside the matching state is ignored.

Test Plan:
- Reset 2 cycles, then 0x005303b3 (add x7,x6,x5) with imem_ready=1:
  - states 0,1,2,4,0; alu_op=0 in EXECUTE
  - reg_write=1, wb_sel=0 in WRITEBACK
  - instret=1 after 4 cycles.
- 0x405303b3 (sub) -> alu_op=1 in EXECUTE. 0x00012083 (lw x1,0(x2)) with dmem_ready held low 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WRITEBACK wb_sel=1, reg_write=1.
- 0x00000463 (beq x0,x0,8):
  - alu_zero=1 -> EXECUTE pc_write=1, pc_src=1, back to FETCH after 3 cycles.
  - alu_zero=0 -> pc_write=0.
- 0x00000000 -> DECODE then TRAP; trap=1 and all strobes stay 0 for 20 cycles; reset returns state=0, trap=0.
- imem_ready held low 16 cycles -> TRAP. Separately, reset asserted in MEM -> next cycle state=0, dmem_req=0, instret unchanged.
- Preload instret near wrap (force 0xFFFFFFFF), retire an add with rd=x0 (0x00530033) -> reg_write=0 in WRITEBACK, instret=0.
